unidade_controle_jogo: RTL
==========================

Name: unidade_controle_jogo

Overview:
- Moore control FSM for the PoliLobinho game; sits directly upstream of the datapath `fluxo_dados` and drives all of its control inputs.
- Sequences the whole game:
  - seed capture;
  - night turns for each of the 5 players;
  - night elimination;
  - day vote and lynch;
  - win detection.
- Consumes the datapath status outputs `CJ_fim`, `jogador_vivo`, `jogou`, `votou`, `acertou` and `sinal_lobo_ganhou`.
- Button inputs arrive already as 1-cycle pulses from `edge_detector` instances.

Parameters:
- TIMEOUT_CYCLES, 50000000: idle-wait limit in clock cycles; used only with `TIMEOUT_EN`.
- TW, 26: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iniciar  in  1  start/restart pulse
- confirmar  in  1  confirm pulse; `jogador_escolhido` goes straight to the datapath
- CJ_fim  in  1  player counter at its last player (4)
- jogador_vivo  in  1  current player alive
- jogou  in  1  last night action valid
- votou  in  1  last vote valid
- acertou  in  1  voted player is the wolf
- sinal_lobo_ganhou  in  1  3 deaths reached
- rst_global, zera_CS, zera_CJ, inc_seed, e_seed_reg, inc_jogador, mostra_classe, processar_acao, avaliar_eliminacao, voto, morra  out  1 each  datapath controls
- fim_aldeia  out  1  village won
- fim_lobo  out  1  wolf won
- db_estado  out  5  current state code

Behaviour:
- General rules:
  - Single clock domain; synchronous active-high reset.
  - `reset` forces INICIAL at any time, including mid-game.
  - All outputs are Moore (decoded from state only); every output is 0 except as listed per state.
  - After reset, the first state is INICIAL.
  - `confirmar` and `iniciar` are ignored in states that do not wait on them.
- State list (code: state: outputs/actions; transition):
  - 0 INICIAL: `rst_global`, `zera_CS`, `zera_CJ`; next ESPERA_INICIO.
  - 1 ESPERA_INICIO: `inc_seed` every cycle, giving a free-running seed address; on `iniciar` go to CARREGA_SEED.
  - 2 CARREGA_SEED: `e_seed_reg`; next NOITE_PREP.
  - 3 NOITE_PREP: `zera_CJ`; next VERIFICA_JOGADOR.
  - 4 VERIFICA_JOGADOR: `jogador_vivo` ? MOSTRA_CLASSE : PROXIMO.
  - 5 MOSTRA_CLASSE: `mostra_classe`; on `confirmar` go to PROCESSA.
  - 6 PROCESSA: `mostra_classe`, `processar_acao`; next CHECA_JOGADA.
  - 7 CHECA_JOGADA: `jogou` ? PROXIMO : MOSTRA_CLASSE. An invalid target means a retry; `jogou` is registered, so it is valid here.
  - 8 PROXIMO: if `CJ_fim` go to ELIMINA; else assert `inc_jogador` and go to VERIFICA_JOGADOR. `inc_jogador` is never asserted when `CJ_fim`=1.
  - 9 ELIMINA: `avaliar_eliminacao`; next CHECA_NOITE.
  - 10 CHECA_NOITE: `sinal_lobo_ganhou` ? FIM_LOBO : DIA_VOTO. `mortes` has already been updated at this point.
  - 11 DIA_VOTO: on `confirmar` go to VOTA.
  - 12 VOTA: `voto`; next CHECA_VOTO.
  - 13 CHECA_VOTO: `votou` ? MORRE : DIA_VOTO. Voting for a dead player means re-vote.
  - 14 MORRE: `morra`; next CHECA_DIA.
  - 15 CHECA_DIA: `acertou` ? FIM_ALDEIA : (`sinal_lobo_ganhou` ? FIM_LOBO : NOITE_PREP). `acertou` has priority.
  - 16 FIM_ALDEIA: `fim_aldeia`=1; on `iniciar` go to INICIAL.
  - 17 FIM_LOBO: `fim_lobo`=1; on `iniciar` go to INICIAL.
- Latency per night turn (no retry) is 4 cycles plus the wait for `confirmar`.
- Unused state codes 18–31 go to INICIAL.
- `db_estado` equals the state code.

Optional Feature:
- Macro `UNIDADE_CONTROLE_TIMEOUT_EN`.
- When defined:
  - A TW-bit counter clears on every state change and counts while in MOSTRA_CLASSE or DIA_VOTO.
  - At TIMEOUT_CYCLES-1 without `confirmar`:
    - MOSTRA_CLASSE goes to PROXIMO; the player is skipped and `processar_acao` is not pulsed.
    - DIA_VOTO goes to NOITE_PREP; there is no lynch.
  - `confirmar` in the same cycle as the timeout wins.
- When undefined: no counter is built, and both states wait indefinitely.

Decomposition:
- Package `lobinho_pkg`:
  - state enum/localparams (5-bit codes above);
  - class codes ALDEAO=2'b00, LOBO=2'b01, MEDICO=2'b10, NENHUMA=2'b11;
  - NUM_JOGADORES=5;
  - LIMITE_MORTES=3.
- No sub-module required. The timeout counter may reuse `contador_m` (M=TIMEOUT_CYCLES, N=TW) with `zera` driven by the state-change pulse.

Test Plan:
- Reset in DIA_VOTO -> next cycle `db_estado`=0 and `rst_global`=1; the cycle after, `db_estado`=1 and `inc_seed`=1.
- `iniciar` at cycle 7 of ESPERA_INICIO -> `e_seed_reg` pulses once, then `zera_CJ` pulses once; `db_estado` sequence is 2,3,4.
- Night with all alive and `jogou`=1 -> exactly 5 `processar_acao` pulses, 4 `inc_jogador` pulses and 1 `avaliar_eliminacao` pulse; with a player dead (`jogador_vivo`=0 at that index) -> that player gets no `mostra_classe`.
- `jogou`=0 on the first attempt -> returns to state 5, and a second `confirmar` gives a second `processar_acao` for the same player.
- Day: `votou`=0 -> back to 11 with no `morra`; then `votou`=1 and `acertou`=1 -> `morra` pulses once, and state 16 is reached with `fim_aldeia` held until `iniciar`.
- Day with `acertou`=0 and `sinal_lobo_ganhou`=1 in CHECA_DIA -> state 17 with `fim_lobo`=1. With `UNIDADE_CONTROLE_TIMEOUT_EN` and TIMEOUT_CYCLES=8 -> MOSTRA_CLASSE exits to PROXIMO after 8 cycles without `confirmar`.

Source files
------------

// File: rtl/lobinho_pkg.sv
// Shared definitions for the PoliLobinho game: controller state codes,
// player class codes, game constants and the Moore output decode.
package lobinho_pkg;

  localparam int NUM_JOGADORES = 5;
  localparam int LIMITE_MORTES = 3;

  // Controller state codes; db_estado exposes these values directly.
  typedef enum logic [4:0] {
    INICIAL          = 5'd0,
    ESPERA_INICIO    = 5'd1,
    CARREGA_SEED     = 5'd2,
    NOITE_PREP       = 5'd3,
    VERIFICA_JOGADOR = 5'd4,
    MOSTRA_CLASSE    = 5'd5,
    PROCESSA         = 5'd6,
    CHECA_JOGADA     = 5'd7,
    PROXIMO          = 5'd8,
    ELIMINA          = 5'd9,
    CHECA_NOITE      = 5'd10,
    DIA_VOTO         = 5'd11,
    VOTA             = 5'd12,
    CHECA_VOTO       = 5'd13,
    MORRE            = 5'd14,
    CHECA_DIA        = 5'd15,
    FIM_ALDEIA       = 5'd16,
    FIM_LOBO         = 5'd17
  } estado_t;

  // Player class codes as stored by the datapath.
  typedef enum logic [1:0] {
    ALDEAO  = 2'b00,
    LOBO    = 2'b01,
    MEDICO  = 2'b10,
    NENHUMA = 2'b11
  } classe_t;

  // Datapath controls decoded from the state. 'proximo' marks the PROXIMO
  // state; the top gates it with CJ_fim to form inc_jogador.
  typedef struct packed {
    logic rst_global;
    logic zera_CS;
    logic zera_CJ;
    logic inc_seed;
    logic e_seed_reg;
    logic proximo;
    logic mostra_classe;
    logic processar_acao;
    logic avaliar_eliminacao;
    logic voto;
    logic morra;
    logic fim_aldeia;
    logic fim_lobo;
  } controle_t;

  // Moore decode: every control is 0 except those listed for the state.
  function automatic controle_t decodifica(input estado_t e);
    controle_t c;
    c = '0;
    case (e)
      INICIAL: begin
        c.rst_global = 1'b1;
        c.zera_CS    = 1'b1;
        c.zera_CJ    = 1'b1;
      end
      ESPERA_INICIO: c.inc_seed   = 1'b1;
      CARREGA_SEED:  c.e_seed_reg = 1'b1;
      NOITE_PREP:    c.zera_CJ    = 1'b1;
      MOSTRA_CLASSE: c.mostra_classe = 1'b1;
      PROCESSA: begin
        c.mostra_classe  = 1'b1;
        c.processar_acao = 1'b1;
      end
      PROXIMO:    c.proximo            = 1'b1;
      ELIMINA:    c.avaliar_eliminacao = 1'b1;
      VOTA:       c.voto               = 1'b1;
      MORRE:      c.morra              = 1'b1;
      FIM_ALDEIA: c.fim_aldeia         = 1'b1;
      FIM_LOBO:   c.fim_lobo           = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo.sv
// Control FSM for the PoliLobinho game. Sequences seed capture, the night
// turns of every player, night elimination, day vote/lynch and win detection,
// driving all control inputs of fluxo_dados.
// Optional build macro UNIDADE_CONTROLE_TIMEOUT_EN adds an idle timeout to the
// MOSTRA_CLASSE and DIA_VOTO wait states.
module unidade_controle_jogo
  import lobinho_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TW             = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirmar,
  input  logic       CJ_fim,
  input  logic       jogador_vivo,
  input  logic       jogou,
  input  logic       votou,
  input  logic       acertou,
  input  logic       sinal_lobo_ganhou,
  output logic       rst_global,
  output logic       zera_CS,
  output logic       zera_CJ,
  output logic       inc_seed,
  output logic       e_seed_reg,
  output logic       inc_jogador,
  output logic       mostra_classe,
  output logic       processar_acao,
  output logic       avaliar_eliminacao,
  output logic       voto,
  output logic       morra,
  output logic       fim_aldeia,
  output logic       fim_lobo,
  output logic [4:0] db_estado
);

  // The timeout counter must be able to reach TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES > (1 << TW)) begin : g_tw_check
    $error("TW too narrow for TIMEOUT_CYCLES");
  end

  estado_t   estado;
  estado_t   estado_next;
  controle_t ctrl_q;
  logic      expirou;

  // Next-state logic for the whole game sequence.
  // NOTE: default assignment first so no path through the case leaves
  // estado_next unassigned, which would otherwise infer a latch.
  always_comb begin
    estado_next = estado;
    case (estado)
      INICIAL:          estado_next = ESPERA_INICIO;
      ESPERA_INICIO:    if (iniciar) estado_next = CARREGA_SEED;
      CARREGA_SEED:     estado_next = NOITE_PREP;
      NOITE_PREP:       estado_next = VERIFICA_JOGADOR;
      VERIFICA_JOGADOR: estado_next = jogador_vivo ? MOSTRA_CLASSE : PROXIMO;
      MOSTRA_CLASSE: begin
        // confirmar wins over a timeout in the same cycle
        if (confirmar)    estado_next = PROCESSA;
        else if (expirou) estado_next = PROXIMO;
      end
      PROCESSA:         estado_next = CHECA_JOGADA;
      CHECA_JOGADA:     estado_next = jogou ? PROXIMO : MOSTRA_CLASSE;
      PROXIMO:          estado_next = CJ_fim ? ELIMINA : VERIFICA_JOGADOR;
      ELIMINA:          estado_next = CHECA_NOITE;
      CHECA_NOITE:      estado_next = sinal_lobo_ganhou ? FIM_LOBO : DIA_VOTO;
      DIA_VOTO: begin
        if (confirmar)    estado_next = VOTA;
        else if (expirou) estado_next = NOITE_PREP;
      end
      VOTA:             estado_next = CHECA_VOTO;
      CHECA_VOTO:       estado_next = votou ? MORRE : DIA_VOTO;
      MORRE:            estado_next = CHECA_DIA;
      CHECA_DIA: begin
        if (acertou)                estado_next = FIM_ALDEIA;
        else if (sinal_lobo_ganhou) estado_next = FIM_LOBO;
        else                        estado_next = NOITE_PREP;
      end
      FIM_ALDEIA:       if (iniciar) estado_next = INICIAL;
      FIM_LOBO:         if (iniciar) estado_next = INICIAL;
      default:          estado_next = INICIAL;
    endcase
  end

  // State register with registered Moore outputs decoded from the next state,
  // so outputs line up with db_estado in the same cycle.
  // NOTE: non-blocking assignments for all sequential state so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
      ctrl_q <= decodifica(INICIAL);
    end else begin
      estado <= estado_next;
      ctrl_q <= decodifica(estado_next);
    end
  end

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  logic [TW-1:0] tmo_cnt;
  logic          em_espera;

  assign em_espera = (estado == MOSTRA_CLASSE) || (estado == DIA_VOTO);
  assign expirou   = em_espera && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter: restarts on every state change, runs only while waiting.
  always_ff @(posedge clock) begin
    if (reset || (estado_next != estado)) begin
      tmo_cnt <= '0;
    end else if (em_espera) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign expirou = 1'b0;
`endif

  assign rst_global         = ctrl_q.rst_global;
  assign zera_CS            = ctrl_q.zera_CS;
  assign zera_CJ            = ctrl_q.zera_CJ;
  assign inc_seed           = ctrl_q.inc_seed;
  assign e_seed_reg         = ctrl_q.e_seed_reg;
  // The player counter must never advance past the last player.
  assign inc_jogador        = ctrl_q.proximo & ~CJ_fim;
  assign mostra_classe      = ctrl_q.mostra_classe;
  assign processar_acao     = ctrl_q.processar_acao;
  assign avaliar_eliminacao = ctrl_q.avaliar_eliminacao;
  assign voto               = ctrl_q.voto;
  assign morra              = ctrl_q.morra;
  assign fim_aldeia         = ctrl_q.fim_aldeia;
  assign fim_lobo           = ctrl_q.fim_lobo;
  assign db_estado          = estado;

endmodule
